vec_loader: RTL
===============

Name: vec_loader

Overview:
- Writer-side counterpart of the vector ROM read channel. Accepts a narrow word stream from the PS/DMA side and packs each run of WORD_WIDTH-bit words into one DATA_WIDTH-bit vector.
- Writes each packed vector into the vector RAM over an aw/w handshake, at sequential addresses 0..VEC_NUM-1.
- Sits ahead of the obs/nav vector stores, so observation vectors can be reloaded at run time instead of only from an init file.

Parameters:
DATA_WIDTH, 1100, bits per vector
WORD_WIDTH, 32, bits per input stream word
VEC_NUM, 49, vectors loaded per start
ADDR_WIDTH, 6, awaddr width; must satisfy 2^ADDR_WIDTH >= VEC_NUM
(derived) WPV = ceil(DATA_WIDTH/WORD_WIDTH), 35 at defaults; the last word contributes DATA_WIDTH-(WPV-1)*WORD_WIDTH bits (12 at defaults)

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to load VEC_NUM vectors; sampled only in IDLE
s_valid  in  1  input word valid
s_ready  out  1  input word ready
s_data  in  WORD_WIDTH  input word
s_last  in  1  marks the final word of a vector; used for checking only
awvalid  out  1  write request valid
awready  in  1  RAM accepts the write
awaddr  out  ADDR_WIDTH  vector index
wdata  out  DATA_WIDTH  packed vector, valid together with awvalid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last vector has been written
frame_err  out  1  sticky s_last mismatch flag

Behaviour:
- Reset (async, rst=1): state=IDLE; word_cnt=0, vec_cnt=0. Outputs: s_ready=0, awvalid=0, awaddr=0, wdata=0, busy=0, done=0, frame_err=0.
- State IDLE:
  - start=1 moves to FILL.
  - On that transition: clear vec_cnt, word_cnt, wdata and frame_err.
- State FILL:
  - s_ready=1, awvalid=0.
  - A beat is accepted when s_valid&s_ready.
  - Word k (k=word_cnt) is written LSB-first to wdata[k*WORD_WIDTH +: WORD_WIDTH], truncated at DATA_WIDTH.
  - Bits of the last word above DATA_WIDTH are discarded.
  - After each accepted beat, word_cnt increments.
  - On the beat with word_cnt==WPV-1: word_cnt returns to 0 and the state moves to WRITE.
- State WRITE:
  - s_ready=0, awvalid=1, awaddr=vec_cnt.
  - wdata is held stable until awvalid&awready.
  - On awvalid&awready with vec_cnt==VEC_NUM-1: go to DONE.
  - Otherwise: vec_cnt increments, wdata clears to 0, and the state returns to FILL.
- State DONE:
  - done=1 for exactly one cycle, then IDLE.
  - vec_cnt resets to 0.
- Latency:
  - The last word is accepted in cycle N; awvalid is high from cycle N+1.
  - With awready tied high, one vector takes WPV+1 cycles: 36 at defaults.
  - A full load takes VEC_NUM*(WPV+1)+1 cycles from the first accepted word to done.
- Handshake rules:
  - awvalid, once high, stays high with awaddr and wdata unchanged until awready is seen. There is no retraction.
  - awready high while awvalid=0 is ignored.
  - s_valid high in IDLE, WRITE or DONE is not accepted (s_ready=0). The upstream source must hold its data.
- frame_err:
  - Set on any accepted beat where s_last != (word_cnt==WPV-1).
  - It is sticky until the next start; start in IDLE clears it.
  - Packing continues on word_cnt; there is no resynchronisation to s_last.
- start:
  - Ignored while busy=1.
  - A start in the same cycle as the DONE→IDLE transition is ignored. A new start is honoured one cycle after done.
- Reset mid-operation: returns immediately to IDLE with all outputs at their reset values. A partially packed vector is dropped and no write is issued.

Test Plan:
- Basic load: rst, start, stream 49*35 words with s_data = word index and awready=1 -> 49 writes at awaddr 0..48. Vector 0 has wdata[31:0]=0, wdata[63:32]=1, wdata[1099:1088]=34[11:0]. done pulses once; frame_err=0.
- Truncation: last word of a vector = 32'hFFFF_FFFF -> wdata[1099:1088]=12'hFFF. No bit of wdata at or above 1100 exists, and no other word is affected.
- Backpressure: awready=0 for 10 cycles at vector 3 -> awvalid stays 1 with awaddr=3 and identical wdata throughout. s_ready=0 the whole time; the write is accepted on the first awready=1.
- Bubbly input: random s_valid gaps -> same 49 vectors as the basic load; busy stays high until done.
- Framing error: s_last asserted on word 33 of vector 5 -> frame_err=1 from the next cycle and through done. Data is still packed by count; the next start clears frame_err.
- Reset mid-load: assert rst during word 20 of vector 2 -> next cycle all outputs are 0 and no write occurs for vector 2. A fresh start then reloads from awaddr 0.

Source files
------------

// File: rtl/vec_loader_if.sv
// Bus bundle between the word-stream source, the vector loader and the vector RAM.
// The slave modport is the loader's view: it takes stream words and awready,
// and drives s_ready plus the aw/w write request.
interface vec_loader_if #(
   parameter int DATA_WIDTH = 1100,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) ();
   logic                  s_valid;
   logic                  s_ready;
   logic [WORD_WIDTH-1:0] s_data;
   logic                  s_last;
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [DATA_WIDTH-1:0] wdata;

   // Loader side
   modport slave (
      input  s_valid, s_data, s_last, awready,
      output s_ready, awvalid, awaddr, wdata
   );

   // Stream source / RAM side
   modport master (
      output s_valid, s_data, s_last, awready,
      input  s_ready, awvalid, awaddr, wdata
   );
endinterface

// File: rtl/vec_loader.sv
// Vector loader: packs WPV stream words (LSB-first) into one DATA_WIDTH vector and
// writes VEC_NUM such vectors to sequential RAM addresses over an aw/w handshake.
module vec_loader #(
   parameter int DATA_WIDTH = 1100,
   parameter int WORD_WIDTH = 32,
   parameter int VEC_NUM    = 49,
   parameter int ADDR_WIDTH = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   vec_loader_if.slave   bus,
   output logic          busy,
   output logic          done,
   output logic          frame_err
);

   localparam int WPV       = (DATA_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int LAST_BITS = DATA_WIDTH - (WPV - 1) * WORD_WIDTH;
   localparam int CNT_W     = (WPV > 1) ? $clog2(WPV) : 1;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      word_cnt_q;
   logic [ADDR_WIDTH-1:0] vec_cnt_q;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  frame_err_q;

   logic beat;       // stream word accepted this cycle
   logic last_word;  // current word completes the vector
   logic aw_hs;      // write request accepted this cycle
   logic last_vec;   // current vector is the final one of the load
   logic start_ok;   // start honoured (only from IDLE)
   logic clear_vec;  // begin a fresh vector in the packing register

   assign beat      = (state_q == FILL) && bus.s_valid;
   assign last_word = (word_cnt_q == CNT_W'(WPV - 1));
   assign aw_hs     = (state_q == WRITE) && bus.awready;
   assign last_vec  = (vec_cnt_q == ADDR_WIDTH'(VEC_NUM - 1));
   assign start_ok  = (state_q == IDLE) && start;
   assign clear_vec = start_ok || (aw_hs && !last_vec);

   // Packing lanes: each word lands in its own slice; the final lane keeps only
   // the low LAST_BITS of the word so nothing is written above DATA_WIDTH.
   for (genvar gi = 0; gi < WPV; gi++) begin : g_lane
      localparam int LO = gi * WORD_WIDTH;
      localparam int W  = (gi == WPV - 1) ? LAST_BITS : WORD_WIDTH;
      logic lane_we;
      assign lane_we = beat && (word_cnt_q == CNT_W'(gi));
      assign wdata_d[LO +: W] = clear_vec ? '0 :
                                lane_we   ? bus.s_data[W-1:0] :
                                            wdata_q[LO +: W];
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = FILL;
         FILL:    if (beat && last_word) state_d = WRITE;
         WRITE:   if (aw_hs) state_d = last_vec ? DONE : FILL;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      bus.s_ready = (state_q == FILL);
      bus.awvalid = (state_q == WRITE);
      bus.awaddr  = (state_q == WRITE) ? vec_cnt_q : '0;
      bus.wdata   = wdata_q;
      busy        = (state_q != IDLE);
      done        = (state_q == DONE);
      frame_err   = frame_err_q;
   end

   // Packing register; held untouched while a write request is pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wdata_q <= '0;
      else     wdata_q <= wdata_d;
   end

   // Word and vector counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt_q <= '0;
         vec_cnt_q  <= '0;
      end else if (start_ok) begin
         word_cnt_q <= '0;
         vec_cnt_q  <= '0;
      end else begin
         if (beat) word_cnt_q <= last_word ? '0 : word_cnt_q + 1'b1;
         if (aw_hs && !last_vec) vec_cnt_q <= vec_cnt_q + 1'b1;
         if (state_q == DONE) vec_cnt_q <= '0;
      end
   end

   // Sticky framing check: s_last must coincide exactly with the counted last word
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 frame_err_q <= 1'b0;
      else if (start_ok)                       frame_err_q <= 1'b0;
      else if (beat && (bus.s_last != last_word)) frame_err_q <= 1'b1;
   end

endmodule
